// File: rtl/mac_seq_if.sv
// mac_seq port bundle: request/result, operand memory reads and mac drive.
// slave is the sequencer's view; master is the surrounding datapath's view.
interface mac_seq_if #(
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 26
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [7:0]        rdata_a;
  logic [7:0]        rdata_b;
  logic [7:0]        a;
  logic [7:0]        b;
  logic              clr_n;
  logic [ACC_W-1:0]  acc;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;

  modport slave (
    input  start, len, base_a, base_b,
    input  rdata_a, rdata_b, acc,
    output addr_a, addr_b, a, b, clr_n,
    output busy, done, result
  );

  modport master (
    output start, len, base_a, base_b,
    output rdata_a, rdata_b, acc,
    input  addr_a, addr_b, a, b, clr_n,
    input  busy, done, result
  );
endinterface

// File: rtl/mac_seq.sv
// Dot-product sequencer: clears mac, streams len operand pairs from two
// sync-read memories, then captures the final accumulator into result.
module mac_seq #(
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 26
) (
  input  logic     clk,
  input  logic     rst,
  mac_seq_if.slave io
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CLR  = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] CAPT = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nx;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              done;
  logic [ACC_W-1:0]  result;

  assign cnt_nx = cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      len_q  <= '0;
      cnt    <= '0;
      addr_a <= '0;
      addr_b <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (io.start && (io.len != '0)) begin
            len_q  <= io.len;
            cnt    <= '0;
            addr_a <= io.base_a;
            addr_b <= io.base_b;
            state  <= CLR;
          end
        end
        CLR: begin
          addr_a <= addr_a + 1'b1;
          addr_b <= addr_b + 1'b1;
          state  <= ACC;
        end
        ACC: begin
          addr_a <= addr_a + 1'b1;
          addr_b <= addr_b + 1'b1;
          cnt    <= cnt_nx;
          if (cnt_nx == len_q)
            state <= CAPT;
        end
        CAPT: begin
          result <= io.acc;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operands are zero outside ACC so the mac accumulator holds its value.
  assign io.a      = (state == ACC) ? io.rdata_a : 8'd0;
  assign io.b      = (state == ACC) ? io.rdata_b : 8'd0;
  assign io.clr_n  = (state != CLR);
  assign io.busy   = (state != IDLE);
  assign io.addr_a = addr_a;
  assign io.addr_b = addr_b;
  assign io.done   = done;
  assign io.result = result;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: memory and mac models around the DUT, results
// compared against a plain-arithmetic dot product of the memory contents.
module tb_mac_seq;
  localparam int AW = 10;
  localparam int CW = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];

  always #5 clk = ~clk;

  mac_seq_if #(.ADDR_W(AW), .ACC_W(CW)) bus ();

  mac_seq #(.ADDR_W(AW), .ACC_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always @(posedge clk) begin
    bus.rdata_a <= mem_a[bus.addr_a];
    bus.rdata_b <= mem_b[bus.addr_b];
    if (!bus.clr_n)
      bus.acc <= '0;
    else
      bus.acc <= bus.acc
        + CW'(int'($signed(bus.a)) * int'($signed(bus.b)));
  end

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] model(int n, int ba, int bb);
    longint s = 0;
    for (int i = 0; i < n; i++)
      s += longint'($signed(mem_a[(ba + i) % 1024]))
         * longint'($signed(mem_b[(bb + i) % 1024]));
    return CW'(s);
  endfunction

  task automatic rand_mem();
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  task automatic run(input string tag, input int n, input int ba,
                     input int bb, input bit poke,
                     input logic [CW-1:0] exp);
    int lat = -1;
    int clo = 0;
    bus.start  = 1'b1;
    bus.len    = (AW+1)'(n);
    bus.base_a = AW'(ba);
    bus.base_b = AW'(bb);
    @(posedge clk);
    for (int k = 0; k < n + 8; k++) begin
      #1;
      if (k == 0) begin
        bus.start = 1'b0;
        chk({tag, "_busy"}, longint'(bus.busy), 1);
        chk({tag, "_done_lo"}, longint'(bus.done), 0);
      end
      if (poke && k == 2) begin
        bus.start  = 1'b1;
        bus.len    = (AW+1)'(5);
        bus.base_a = AW'(7);
      end
      if (poke && k == 3)
        bus.start = 1'b0;
      if (!bus.clr_n)
        clo++;
      if (bus.done) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    chk({tag, "_lat"}, longint'(lat), longint'(n + 2));
    chk({tag, "_clr"}, longint'(clo), 1);
    chk({tag, "_busy_lo"}, longint'(bus.busy), 0);
    chk({tag, "_result"}, longint'(bus.result), longint'(exp));
  endtask

  initial begin
    int seen;
    int n;
    int ba;
    int bb;
    bus.start  = 1'b0;
    bus.len    = '0;
    bus.base_a = '0;
    bus.base_b = '0;
    bus.acc    = '0;
    rand_mem();

    #12;
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_result", longint'(bus.result), 0);
    chk("rst_clr_n", longint'(bus.clr_n), 1);
    chk("rst_a", longint'(bus.a), 0);
    chk("rst_addr", longint'(bus.addr_a), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    mem_a[0] = 8'd2; mem_a[1] = 8'hFE; mem_a[2] = 8'hFD;
    mem_b[0] = 8'd5; mem_b[1] = 8'd5;  mem_b[2] = 8'd8;
    run("mix", 3, 0, 0, 1'b0, 26'h3FFFFE8);
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      mem_a[i] = 8'd126;
      mem_b[i] = 8'd126;
    end
    run("pos", 3, 0, 0, 1'b0, 26'd47628);
    for (int i = 0; i < 3; i++) begin
      mem_a[i] = 8'h80;
      mem_b[i] = 8'h7F;
    end
    run("neg_b2b", 3, 0, 0, 1'b0, 26'h3FF4180);
    @(negedge clk);

    mem_a[1023] = 8'd3; mem_a[0] = 8'd7;
    mem_b[0] = 8'd11;   mem_b[1] = 8'hFB;
    run("wrap", 2, 1023, 0, 1'b0, 26'h3FFFFFE);
    @(negedge clk);

    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'd1;
      mem_b[i] = 8'd1;
    end
    run("max", 1024, 0, 0, 1'b0, 26'd1024);
    @(negedge clk);

    bus.start = 1'b1;
    bus.len   = '0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.busy || bus.done)
        seen = 1;
      @(posedge clk);
      #1;
    end
    chk("len0_ignored", longint'(seen), 0);

    rand_mem();
    run("poke", 6, 100, 300, 1'b1, model(6, 100, 300));
    @(negedge clk);

    bus.start  = 1'b1;
    bus.len    = (AW+1)'(4);
    bus.base_a = AW'(20);
    bus.base_b = AW'(40);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", longint'(bus.busy), 0);
    chk("mid_clr_n", longint'(bus.clr_n), 1);
    chk("mid_result", longint'(bus.result), 0);
    chk("mid_a", longint'(bus.a), 0);
    chk("mid_addr", longint'(bus.addr_b), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy)
        seen = 1;
    end
    chk("mid_no_done", longint'(seen), 0);
    run("post_rst", 2, 500, 900, 1'b0, model(2, 500, 900));

    for (int r = 0; r < 8; r++) begin
      n  = int'($urandom_range(1, 40));
      ba = int'($urandom_range(0, 1023));
      bb = int'($urandom_range(0, 1023));
      run($sformatf("rnd%0d", r), n, ba, bb, 1'($urandom),
          model(n, ba, bb));
      if ($urandom_range(0, 1) == 1)
        @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
